// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer.
// Entry record plus default depth and the hard-wired zero register.
package rob_pkg;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic [4:0]  dest;
        logic [31:0] data;
    } rob_entry_t;

    localparam int DEPTH_DEFAULT = 8;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reorder_buffer_match.sv
// Youngest-first producer search for one operand port.
// Walks backward from tail-1 and stops after visiting head.
module rob_match #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] vld,
    input  logic [4:0]       dst [DEPTH],
    input  logic [TAG_W-1:0] head,
    input  logic [TAG_W-1:0] tail,
    input  logic [4:0]       src,
    output logic             hit,
    output logic [TAG_W-1:0] tag
);

    logic [TAG_W-1:0] idx;
    logic             stop;

    // first valid match going backward from the newest slot wins
    always_comb begin
        hit  = 1'b0;
        tag  = '0;
        stop = 1'b0;
        idx  = tail;
        for (int i = 0; i < DEPTH; i++) begin
            idx = idx - TAG_W'(1);
            if (!stop && vld[idx] && dst[idx] == src) begin
                hit  = 1'b1;
                tag  = idx;
                stop = 1'b1;
            end
            if (idx == head) stop = 1'b1;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocate, out-of-order writeback, in-order commit.
// Optional ROB_WB_BYPASS_EN forwards a same-cycle writeback to the operand muxes.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_dest,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_data,
    input  logic [4:0]       AR1_RF,
    input  logic [4:0]       AR2_RF,
    output logic [31:0]      ROB_forwA,
    output logic [31:0]      ROB_forwB,
    output logic             ROB_forwselA,
    output logic             ROB_forwselB,
    output logic             ROB_stallA,
    output logic             ROB_stallB,
    output logic             RF_we,
    output logic [4:0]       RF_wa,
    output logic [31:0]      RF_wd,
    output logic [TAG_W:0]   count
);

    localparam logic [TAG_W:0] FULL = (TAG_W + 1)'(DEPTH);

    rob_entry_t       ents [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [4:0]       dst [DEPTH];
    logic [TAG_W-1:0] head, tail;
    logic             do_alloc, do_commit;
    logic             hit_a, hit_b;
    logic [TAG_W-1:0] tag_a, tag_b;

    assign alloc_ready = (count != FULL);
    assign alloc_tag   = tail;
    assign do_alloc    = alloc_valid && alloc_ready;
    assign do_commit   = ents[head].valid && ents[head].done;

    // flatten the fields the producer search needs
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            vld[i] = ents[i].valid;
            dst[i] = ents[i].dest;
        end
    end

    // entry array, pointers, occupancy and registered RF write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            RF_we <= 1'b0;
            RF_wa <= '0;
            RF_wd <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) ents[i].valid <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            RF_we <= 1'b0;
        end else begin
            if (wb_valid && ents[wb_tag].valid) begin
                ents[wb_tag].data <= wb_data;
                ents[wb_tag].done <= 1'b1;
            end
            RF_we <= 1'b0;
            if (do_commit) begin
                RF_we <= (ents[head].dest != REG_ZERO);
                RF_wa <= ents[head].dest;
                RF_wd <= ents[head].data;
                ents[head].valid <= 1'b0;
                head <= head + TAG_W'(1);
            end
            if (do_alloc) begin
                ents[tail] <= '{valid: 1'b1, done: 1'b0,
                                dest: alloc_dest, data: 32'd0};
                tail <= tail + TAG_W'(1);
            end
            count <= count + (TAG_W + 1)'(do_alloc)
                           - (TAG_W + 1)'(do_commit);
        end
    end

    rob_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_match_a (
        .vld(vld), .dst(dst), .head(head), .tail(tail),
        .src(AR1_RF), .hit(hit_a), .tag(tag_a)
    );

    rob_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_match_b (
        .vld(vld), .dst(dst), .head(head), .tail(tail),
        .src(AR2_RF), .hit(hit_b), .tag(tag_b)
    );

    // port A operand: forward a finished producer, stall on a pending one
    always_comb begin
        ROB_forwA    = '0;
        ROB_forwselA = 1'b0;
        ROB_stallA   = 1'b0;
        if (AR1_RF != REG_ZERO && hit_a) begin
            if (ents[tag_a].done) begin
                ROB_forwselA = 1'b1;
                ROB_forwA    = ents[tag_a].data;
            end
`ifdef ROB_WB_BYPASS_EN
            else if (wb_valid && wb_tag == tag_a) begin
                ROB_forwselA = 1'b1;
                ROB_forwA    = wb_data;
            end
`endif
            else begin
                ROB_stallA = 1'b1;
            end
        end
    end

    // port B operand: same resolution as port A
    always_comb begin
        ROB_forwB    = '0;
        ROB_forwselB = 1'b0;
        ROB_stallB   = 1'b0;
        if (AR2_RF != REG_ZERO && hit_b) begin
            if (ents[tag_b].done) begin
                ROB_forwselB = 1'b1;
                ROB_forwB    = ents[tag_b].data;
            end
`ifdef ROB_WB_BYPASS_EN
            else if (wb_valid && wb_tag == tag_b) begin
                ROB_forwselB = 1'b1;
                ROB_forwB    = wb_data;
            end
`endif
            else begin
                ROB_stallB = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table plus corner sequences.
// Expected values are hand-derived; bypass check follows ROB_WB_BYPASS_EN.
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic [4:0]  alloc_dest;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [31:0] wb_data;
    logic [4:0]  AR1_RF, AR2_RF;
    logic [31:0] ROB_forwA, ROB_forwB;
    logic        ROB_forwselA, ROB_forwselB;
    logic        ROB_stallA, ROB_stallB;
    logic        RF_we;
    logic [4:0]  RF_wa;
    logic [31:0] RF_wd;
    logic [3:0]  count;

    int tests;
    int fails;

    reorder_buffer #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .AR1_RF(AR1_RF), .AR2_RF(AR2_RF),
        .ROB_forwA(ROB_forwA), .ROB_forwB(ROB_forwB),
        .ROB_forwselA(ROB_forwselA), .ROB_forwselB(ROB_forwselB),
        .ROB_stallA(ROB_stallA), .ROB_stallB(ROB_stallB),
        .RF_we(RF_we), .RF_wa(RF_wa), .RF_wd(RF_wd),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        av;
        logic [4:0]  ad;
        logic        wv;
        logic [2:0]  wt;
        logic [31:0] wd;
        logic [4:0]  ar1;
        logic [3:0]  cnt;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] rwd;
        logic        sel;
        logic [31:0] fw;
        logic        stl;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    function automatic vec_t mk(
        logic av, logic [4:0] ad, logic wv, logic [2:0] wt,
        logic [31:0] wd, logic [4:0] ar1, logic [3:0] cnt,
        logic we, logic [4:0] wa, logic [31:0] rwd,
        logic sel, logic [31:0] fw, logic stl);
        vec_t v;
        v.av = av; v.ad = ad; v.wv = wv; v.wt = wt; v.wd = wd;
        v.ar1 = ar1; v.cnt = cnt; v.we = we; v.wa = wa;
        v.rwd = rwd; v.sel = sel; v.fw = fw; v.stl = stl;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc_valid = 0; alloc_dest = 0;
        wb_valid = 0; wb_tag = 0; wb_data = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        // first-commit, out-of-order completion, youngest-producer, r0
        tbl[0]  = mk(1, 3, 0, 0, 0,        3, 1, 0, 0, 0,        0, 0,        1);
        tbl[1]  = mk(0, 0, 1, 0, 32'h1234, 3, 1, 0, 0, 0,        1, 32'h1234, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,        3, 0, 1, 3, 32'h1234, 0, 0,        0);
        tbl[3]  = mk(1, 1, 0, 0, 0,        0, 1, 0, 0, 0,        0, 0,        0);
        tbl[4]  = mk(1, 2, 0, 0, 0,        0, 2, 0, 0, 0,        0, 0,        0);
        tbl[5]  = mk(1, 3, 0, 0, 0,        0, 3, 0, 0, 0,        0, 0,        0);
        tbl[6]  = mk(1, 4, 0, 0, 0,        0, 4, 0, 0, 0,        0, 0,        0);
        tbl[7]  = mk(0, 0, 1, 3, 32'h33,   3, 4, 0, 0, 0,        1, 32'h33,   0);
        tbl[8]  = mk(0, 0, 1, 1, 32'h11,   1, 4, 0, 0, 0,        1, 32'h11,   0);
        tbl[9]  = mk(0, 0, 1, 4, 32'h44,   4, 3, 1, 1, 32'h11,   1, 32'h44,   0);
        tbl[10] = mk(0, 0, 1, 2, 32'h22,   2, 3, 0, 0, 0,        1, 32'h22,   0);
        tbl[11] = mk(0, 0, 0, 0, 0,        1, 2, 1, 2, 32'h22,   0, 0,        0);
        tbl[12] = mk(0, 0, 0, 0, 0,        0, 1, 1, 3, 32'h33,   0, 0,        0);
        tbl[13] = mk(0, 0, 0, 0, 0,        0, 0, 1, 4, 32'h44,   0, 0,        0);
        tbl[14] = mk(0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0,        0);
        tbl[15] = mk(1, 5, 0, 0, 0,        5, 1, 0, 0, 0,        0, 0,        1);
        tbl[16] = mk(1, 5, 0, 0, 0,        5, 2, 0, 0, 0,        0, 0,        1);
        tbl[17] = mk(0, 0, 1, 5, 32'hA,    5, 2, 0, 0, 0,        0, 0,        1);
        tbl[18] = mk(0, 0, 1, 6, 32'hB,    5, 1, 1, 5, 32'hA,    1, 32'hB,    0);
        tbl[19] = mk(0, 0, 0, 0, 0,        5, 0, 1, 5, 32'hB,    0, 0,        0);
        tbl[20] = mk(1, 0, 0, 0, 0,        0, 1, 0, 0, 0,        0, 0,        0);
        tbl[21] = mk(0, 0, 1, 7, 32'h77,   0, 1, 0, 0, 0,        0, 0,        0);
        tbl[22] = mk(0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0,        0);

        idle();
        AR1_RF = 3;
        AR2_RF = 3;
        rst = 1;
        tick();
        tick();
        rst = 0;

        chk("rst count", 32'(count), 0);
        chk("rst ready", 32'(alloc_ready), 1);
        chk("rst tag", 32'(alloc_tag), 0);
        chk("rst we", 32'(RF_we), 0);
        chk("rst wa", 32'(RF_wa), 0);
        chk("rst wd", RF_wd, 0);
        chk("rst fwd", {ROB_forwA[15:0], ROB_forwB[15:0]}, 0);
        chk("rst sel/stall", {28'd0, ROB_forwselA, ROB_forwselB,
                              ROB_stallA, ROB_stallB}, 0);

        AR2_RF = 0;
        for (int i = 0; i < NV; i++) begin
            alloc_valid = tbl[i].av;
            alloc_dest  = tbl[i].ad;
            wb_valid    = tbl[i].wv;
            wb_tag      = tbl[i].wt;
            wb_data     = tbl[i].wd;
            AR1_RF      = tbl[i].ar1;
            tick();
            chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d we", i), 32'(RF_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("v%0d wa", i), 32'(RF_wa), 32'(tbl[i].wa));
                chk($sformatf("v%0d wd", i), RF_wd, tbl[i].rwd);
            end
            chk($sformatf("v%0d selA", i), 32'(ROB_forwselA), 32'(tbl[i].sel));
            chk($sformatf("v%0d forwA", i), ROB_forwA, tbl[i].fw);
            chk($sformatf("v%0d stallA", i), 32'(ROB_stallA), 32'(tbl[i].stl));
        end
        idle();
        AR1_RF = 0;

        // fill to full; tail wraps back to 0
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1;
            alloc_dest  = 5'(i + 1);
            tick();
        end
        chk("full count", 32'(count), 8);
        chk("full ready", 32'(alloc_ready), 0);
        chk("full tag wrap", 32'(alloc_tag), 0);
        alloc_dest = 9;
        tick();
        chk("full extra alloc", 32'(count), 8);
        idle();
        wb_valid = 1; wb_tag = 0; wb_data = 32'h100;
        tick();
        idle();
        alloc_valid = 1; alloc_dest = 10;
        tick();
        chk("full commit we", 32'(RF_we), 1);
        chk("full commit wa", 32'(RF_wa), 1);
        chk("full commit wd", RF_wd, 32'h100);
        chk("full no bypass count", 32'(count), 7);
        chk("full no bypass tag", 32'(alloc_tag), 0);
        tick();
        chk("refill count", 32'(count), 8);
        chk("refill tag", 32'(alloc_tag), 1);
        chk("refill ready", 32'(alloc_ready), 0);
        idle();

        // flush with a done head plus same-cycle alloc and wb
        flush = 1;
        tick();
        idle();
        chk("flush1 count", 32'(count), 0);
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1;
            alloc_dest  = 5'(11 + i);
            tick();
        end
        idle();
        wb_valid = 1; wb_tag = 0; wb_data = 32'h500;
        tick();
        flush = 1;
        alloc_valid = 1; alloc_dest = 14;
        wb_valid = 1; wb_tag = 1; wb_data = 32'h600;
        tick();
        idle();
        AR1_RF = 11;
        #1;
        chk("flush count", 32'(count), 0);
        chk("flush we", 32'(RF_we), 0);
        chk("flush tag", 32'(alloc_tag), 0);
        chk("flush ready", 32'(alloc_ready), 1);
        chk("flush fwd", {29'd0, ROB_forwselA, ROB_stallA, |ROB_forwA}, 0);
        tick();
        chk("flush no late we", 32'(RF_we), 0);
        alloc_valid = 1; alloc_dest = 15;
        tick();
        idle();
        wb_valid = 1; wb_tag = 0; wb_data = 32'h700;
        tick();
        idle();
        tick();
        chk("post flush we", 32'(RF_we), 1);
        chk("post flush wa", 32'(RF_wa), 15);
        chk("post flush wd", RF_wd, 32'h700);
        AR1_RF = 0;

        // same-cycle writeback to the youngest producer of AR2
        alloc_valid = 1; alloc_dest = 20;
        tick();
        idle();
        AR2_RF = 20;
        wb_valid = 1; wb_tag = 1; wb_data = 32'h55;
        #2;
`ifdef ROB_WB_BYPASS_EN
        chk("byp selB", 32'(ROB_forwselB), 1);
        chk("byp forwB", ROB_forwB, 32'h55);
        chk("byp stallB", 32'(ROB_stallB), 0);
`else
        chk("nobyp selB", 32'(ROB_forwselB), 0);
        chk("nobyp forwB", ROB_forwB, 0);
        chk("nobyp stallB", 32'(ROB_stallB), 1);
`endif
        tick();
        idle();
        chk("wb next selB", 32'(ROB_forwselB), 1);
        chk("wb next forwB", ROB_forwB, 32'h55);
        tick();
        chk("byp commit wa", 32'(RF_wa), 20);
        AR2_RF = 0;

        // reset in the middle of traffic
        alloc_valid = 1; alloc_dest = 21;
        tick();
        idle();
        wb_valid = 1; wb_tag = 2; wb_data = 32'h66;
        tick();
        idle();
        rst = 1;
        tick();
        rst = 0;
        chk("mid rst count", 32'(count), 0);
        chk("mid rst we", 32'(RF_we), 0);
        chk("mid rst wa", 32'(RF_wa), 0);
        chk("mid rst wd", RF_wd, 0);
        chk("mid rst tag", 32'(alloc_tag), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
